// File: rtl/data_sram_responder.sv
// Data SRAM target: byte-lane writes, fixed-latency reads with rvalid.
// Optional DSRAM_RANGE_CHECK_EN adds out-of-range detection and write suppression.
module data_sram_responder #(
    parameter int ADDR_W   = 16,
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_sram_rvalid,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt,
    output logic        range_err
);

    if (READ_LAT < 1 || READ_LAT > 4) begin : g_lat_chk
        $fatal(1, "data_sram_responder: READ_LAT must be 1..4");
    end

    localparam logic [31:0] OOR_DATA = 32'hDEAD_BEEF;

    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              oor;
    logic              wr_req;
    logic              rd_req;
    logic              wr_fire;
    logic              rd_fire;
    logic              unused_addr;

    logic [READ_LAT-1:0] pv;
    logic [31:0]         pd [READ_LAT];

    assign idx    = data_sram_addr[ADDR_W+1:2];
    assign wr_req = data_sram_en && (data_sram_we != 4'b0000);
    assign rd_req = data_sram_en && (data_sram_we == 4'b0000);

`ifdef DSRAM_RANGE_CHECK_EN
    logic range_err_q;

    assign oor         = |data_sram_addr[31:ADDR_W+2];
    assign unused_addr = ^data_sram_addr[1:0];
    assign range_err   = range_err_q;

    // Sticky flag: any accepted out-of-range request sets it until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            range_err_q <= 1'b0;
        end else if (data_sram_en && oor) begin
            range_err_q <= 1'b1;
        end
    end
`else
    assign oor         = 1'b0;
    assign range_err   = 1'b0;
    assign unused_addr = ^{data_sram_addr[31:ADDR_W+2],
                           data_sram_addr[1:0]};
`endif

    // Out-of-range writes never touch the array; reset-cycle requests are dropped.
    assign wr_fire = !reset && wr_req && !oor;
    assign rd_fire = !reset && rd_req;

    // Array write port: only the enabled byte lanes change.
    always_ff @(posedge clk) begin
        if (wr_fire) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_we[i]) begin
                    mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
                end
            end
        end
    end

    // Read latency pipeline; data only advances with a valid so rdata holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            pv <= '0;
            for (int k = 0; k < READ_LAT; k++) begin
                pd[k] <= '0;
            end
        end else begin
            pv[0] <= rd_fire;
            if (rd_fire) begin
                pd[0] <= oor ? OOR_DATA : mem[idx];
            end
            for (int k = 1; k < READ_LAT; k++) begin
                pv[k] <= pv[k-1];
                if (pv[k-1]) begin
                    pd[k] <= pd[k-1];
                end
            end
        end
    end

    // Accepted-request counters, wrapping silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else begin
            if (rd_req) begin
                rd_cnt <= rd_cnt + 32'd1;
            end
            if (wr_req) begin
                wr_cnt <= wr_cnt + 32'd1;
            end
        end
    end

    assign data_sram_rdata  = pd[READ_LAT-1];
    assign data_sram_rvalid = pv[READ_LAT-1];

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder, READ_LAT=1 and READ_LAT=3 side by side.
// Reference memory model predicts read data, counters and the range flag.
module tb_data_sram_responder;

    localparam int AW = 16;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rdata1, rdata3;
    logic        rvalid1, rvalid3;
    logic [31:0] rd_cnt1, rd_cnt3, wr_cnt1, wr_cnt3;
    logic        rerr1, rerr3;

    data_sram_responder #(.ADDR_W(AW), .READ_LAT(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata),
        .data_sram_rdata(rdata1), .data_sram_rvalid(rvalid1),
        .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1), .range_err(rerr1)
    );

    data_sram_responder #(.ADDR_W(AW), .READ_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset),
        .data_sram_en(en), .data_sram_we(we),
        .data_sram_addr(addr), .data_sram_wdata(wdata),
        .data_sram_rdata(rdata3), .data_sram_rvalid(rvalid3),
        .rd_cnt(rd_cnt3), .wr_cnt(wr_cnt3), .range_err(rerr3)
    );

    always #5 clk = ~clk;

    logic [31:0] mref [2**AW];
    exp_t        q1[$];
    exp_t        q3[$];
    logic [31:0] last1, last3;
    logic [31:0] m_rd, m_wr;
    logic        m_err;
    int          cyc;
    bit          mon_en;
    int          total;
    int          passed;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endfunction

    // Reference model: applies one request as seen at a clock edge.
    task automatic model(input logic r, input logic e, input logic [3:0] w,
                         input logic [31:0] a, input logic [31:0] d);
        int unsigned wi;
        logic        o;
        logic [31:0] rv;
        wi = int'(a[AW+1:2]);
`ifdef DSRAM_RANGE_CHECK_EN
        o = (a >> (AW + 2)) != 0;
`else
        o = 1'b0;
`endif
        if (r) begin
            q1.delete();
            q3.delete();
            last1 = '0;
            last3 = '0;
            m_rd  = '0;
            m_wr  = '0;
            m_err = 1'b0;
        end else if (e) begin
            if (o) m_err = 1'b1;
            if (w != 4'b0000) begin
                m_wr = m_wr + 1;
                if (!o) begin
                    for (int i = 0; i < 4; i++)
                        if (w[i]) mref[wi][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                m_rd = m_rd + 1;
                rv = o ? 32'hDEAD_BEEF : mref[wi];
                q1.push_back('{cyc, rv});
                q3.push_back('{cyc + 2, rv});
            end
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        reset = r;
        en    = e;
        we    = w;
        addr  = a;
        wdata = d;
        @(posedge clk);
        cyc++;
        model(r, e, w, a, d);
        #1;
    endtask

    task automatic mon(input int lat, input logic rv, input logic [31:0] rd);
        exp_t        ex;
        int          n;
        logic [31:0] last;
        string       p;
        p    = $sformatf("L%0d", lat);
        n    = (lat == 1) ? q1.size() : q3.size();
        last = (lat == 1) ? last1 : last3;
        if (rv) begin
            if (n == 0) begin
                chk({p, " spurious_rvalid"}, {31'b0, rv}, 32'd0);
            end else begin
                if (lat == 1) ex = q1.pop_front();
                else ex = q3.pop_front();
                chk({p, " rvalid_cycle"}, cyc, ex.due);
                chk({p, " rdata"}, rd, ex.data);
                if (lat == 1) last1 = ex.data;
                else last3 = ex.data;
            end
        end else begin
            chk({p, " rdata_hold"}, rd, last);
            if (n > 0) begin
                ex = (lat == 1) ? q1[0] : q3[0];
                if (ex.due <= cyc) begin
                    chk({p, " missing_rvalid"}, {31'b0, rv}, 32'd1);
                    if (lat == 1) void'(q1.pop_front());
                    else void'(q3.pop_front());
                end
            end
        end
    endtask

    // Monitor: compares outputs against the scoreboard mid-cycle.
    always @(negedge clk) begin
        if (mon_en) begin
            mon(1, rvalid1, rdata1);
            mon(3, rvalid3, rdata3);
            chk("L1 rd_cnt", rd_cnt1, m_rd);
            chk("L3 rd_cnt", rd_cnt3, m_rd);
            chk("L1 wr_cnt", wr_cnt1, m_wr);
            chk("L3 wr_cnt", wr_cnt3, m_wr);
            chk("L1 range_err", {31'b0, rerr1}, {31'b0, m_err});
            chk("L3 range_err", {31'b0, rerr3}, {31'b0, m_err});
        end
    end

    initial begin
        logic [31:0] v;
        logic [31:0] a;
        total  = 0;
        passed = 0;
        cyc    = 0;
        mon_en = 1'b0;
        for (int i = 0; i < 2**AW; i++) begin
            v = (i < 3) ? 32'(i + 1) : $urandom;
            mref[i]       = v;
            u_dut1.mem[i] = v;
            u_dut3.mem[i] = v;
        end

        step(1, 1, 4'hF, 32'h30, 32'h0BAD_0BAD);
        mon_en = 1'b1;
        step(1, 0, 4'h0, 32'h0, 32'h0);

        step(0, 1, 4'hF, 32'h10, 32'h1122_3344);
        step(0, 1, 4'b0010, 32'h10, 32'h0000_AA00);
        step(0, 1, 4'h0, 32'h10, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 32'h0, 32'h0);

        step(0, 1, 4'h0, 32'h0, 32'h0);
        step(0, 1, 4'h0, 32'h4, 32'h0);
        step(0, 1, 4'h0, 32'h8, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 32'h0, 32'h0);

        step(1, 0, 4'h0, 32'h0, 32'h0);
        step(0, 1, 4'hF, 32'h20, 32'hCAFE_F00D);
        step(0, 1, 4'h0, 32'h20, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 32'h0, 32'h0);

        step(0, 1, 4'h0, 32'h20, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 32'h0, 32'h0);
        step(0, 1, 4'h0, 32'h20, 32'h0);

        step(0, 0, 4'hF, 32'h30, 32'hFFFF_FFFF);
        step(0, 1, 4'h0, 32'h30, 32'h0);
        step(0, 1, 4'h0, 32'h34, 32'h1234_5678);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 32'h0, 32'h0);

        step(0, 1, 4'hF, 32'h0004_0000, 32'h5A5A_5A5A);
        step(0, 1, 4'h0, 32'h0004_0000, 32'h0);
        step(0, 1, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 32'h0, 32'h0);

        for (int i = 0; i < 3000; i++) begin
            a = {16'h0, 10'h0, 4'($urandom_range(0, 15)), 2'($urandom)};
            a[7:2] = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0) a[31:18] = 14'($urandom);
            step($urandom_range(0, 99) < 2,
                 $urandom_range(0, 99) < 85,
                 ($urandom_range(0, 9) < 4) ? 4'h0 : 4'($urandom),
                 a, $urandom);
        end

        for (int i = 0; i < 6; i++) step(0, 0, 4'h0, 32'h0, 32'h0);
        mon_en = 1'b0;
        chk("L1 drain", q1.size(), 32'd0);
        chk("L3 drain", q3.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
